// File: rtl/unum4_pkg.sv
// Shared definitions for the unum4 FPU command sequencer: opcodes, flag bit
// positions and the sequencer FSM encoding.
package unum4_pkg;

   localparam int unsigned OPC_W   = 2;
   localparam int unsigned FLAGS_W = 4;

   localparam logic [OPC_W-1:0] OP_ADD = 2'b00;
   localparam logic [OPC_W-1:0] OP_SUB = 2'b01;
   localparam logic [OPC_W-1:0] OP_DIV = 2'b10;
   localparam logic [OPC_W-1:0] OP_MUL = 2'b11;

   localparam int unsigned FLG_OVF = 0;
   localparam int unsigned FLG_UNF = 1;
   localparam int unsigned FLG_DBZ = 2;
   localparam int unsigned FLG_TMO = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } seq_state_t;

   // Assemble a response flag word from individual status bits
   function automatic logic [FLAGS_W-1:0] pack_flags(input logic tmo, input logic dbz,
                                                     input logic unf, input logic ovf);
      logic [FLAGS_W-1:0] f;
      f          = '0;
      f[FLG_TMO] = tmo;
      f[FLG_DBZ] = dbz;
      f[FLG_UNF] = unf;
      f[FLG_OVF] = ovf;
      return f;
   endfunction

endpackage

// File: rtl/unum4_fpu_seq.sv
// Command-side sequencer for the unum4 FPU: accepts one command, pulses run,
// waits for done under a timeout guard, returns result/flags, and keeps
// sticky exception flags. Every output is a register.
module unum4_fpu_seq
   import unum4_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned OPCODE_W = 2,
   parameter int unsigned TIMEOUT  = 127
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [OPCODE_W-1:0] cmd_op,
   input  logic [DATA_W-1:0]   cmd_a,
   input  logic [DATA_W-1:0]   cmd_b,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_data,
   output logic [3:0]          rsp_flags,
   output logic [3:0]          sticky_flags,
   input  logic                sticky_clr,
   output logic                busy,
   output logic                fpu_run,
   output logic [DATA_W-1:0]   fpu_in0,
   output logic [DATA_W-1:0]   fpu_in1,
   output logic [OPCODE_W-1:0] fpu_op,
   input  logic [DATA_W-1:0]   fpu_out0,
   input  logic                fpu_done,
   input  logic                fpu_overflow,
   input  logic                fpu_underflow,
   input  logic                fpu_div_by_zero
);

   localparam int unsigned     CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   seq_state_t state;
   seq_state_t next_state;

   logic [CNT_W-1:0]    wait_cnt;
   logic                accept;
   logic                last_wait;

   logic [CNT_W-1:0]    cnt_d;
   logic [DATA_W-1:0]   in0_d;
   logic [DATA_W-1:0]   in1_d;
   logic [OPCODE_W-1:0] op_d;
   logic [DATA_W-1:0]   data_d;
   logic [3:0]          flags_d;
   logic [3:0]          sticky_d;
   logic                ready_d;
   logic                valid_d;
   logic                busy_d;
   logic                run_d;

   assign accept    = (state == ST_IDLE) && cmd_ready && cmd_valid;
   assign last_wait = (wait_cnt == CNT_LAST);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      unique case (state)
         ST_IDLE: if (accept) next_state = ST_RUN;
         ST_RUN:  next_state = ST_WAIT;
         ST_WAIT: if (fpu_done || last_wait) next_state = ST_RESP;
         ST_RESP: if (rsp_valid && rsp_ready) next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   // Next values for the registered outputs; done takes priority over timeout
   always_comb begin
      cnt_d    = wait_cnt;
      in0_d    = fpu_in0;
      in1_d    = fpu_in1;
      op_d     = fpu_op;
      data_d   = rsp_data;
      flags_d  = rsp_flags;
      sticky_d = sticky_clr ? 4'b0000 : sticky_flags;
      ready_d  = (next_state == ST_IDLE);
      valid_d  = (next_state == ST_RESP);
      busy_d   = (next_state != ST_IDLE);
      run_d    = (next_state == ST_RUN);

      if (accept) begin
         in0_d = cmd_a;
         in1_d = cmd_b;
         op_d  = cmd_op;
      end

      if (state == ST_RUN) cnt_d = '0;

      if (state == ST_WAIT) begin
         cnt_d = wait_cnt + CNT_W'(1);
         if (fpu_done) begin
            data_d   = fpu_out0;
            flags_d  = pack_flags(1'b0, fpu_div_by_zero, fpu_underflow, fpu_overflow);
            sticky_d = sticky_d | flags_d;
         end else if (last_wait) begin
            data_d   = '0;
            flags_d  = pack_flags(1'b1, 1'b0, 1'b0, 1'b0);
            sticky_d = sticky_d | flags_d;
         end
      end
   end

   // Output and counter registers, all cleared while reset is high
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt     <= '0;
         fpu_in0      <= '0;
         fpu_in1      <= '0;
         fpu_op       <= '0;
         rsp_data     <= '0;
         rsp_flags    <= '0;
         sticky_flags <= '0;
         cmd_ready    <= 1'b0;
         rsp_valid    <= 1'b0;
         busy         <= 1'b0;
         fpu_run      <= 1'b0;
      end else begin
         wait_cnt     <= cnt_d;
         fpu_in0      <= in0_d;
         fpu_in1      <= in1_d;
         fpu_op       <= op_d;
         rsp_data     <= data_d;
         rsp_flags    <= flags_d;
         sticky_flags <= sticky_d;
         cmd_ready    <= ready_d;
         rsp_valid    <= valid_d;
         busy         <= busy_d;
         fpu_run      <= run_d;
      end
   end

endmodule

// File: tb/tb_unum4_fpu_seq.sv
// Self-checking bench for unum4_fpu_seq with a behavioural FPU (result a+b,
// configurable latency and flags) and a transaction-level expectation model.
module tb_unum4_fpu_seq;
   import unum4_pkg::*;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned OPCODE_W = 2;
   localparam int unsigned TIMEOUT  = 127;

   logic                clk;
   logic                rst;
   logic                cmd_valid;
   logic                cmd_ready;
   logic [OPCODE_W-1:0] cmd_op;
   logic [DATA_W-1:0]   cmd_a;
   logic [DATA_W-1:0]   cmd_b;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [DATA_W-1:0]   rsp_data;
   logic [3:0]          rsp_flags;
   logic [3:0]          sticky_flags;
   logic                sticky_clr;
   logic                busy;
   logic                fpu_run;
   logic [DATA_W-1:0]   fpu_in0;
   logic [DATA_W-1:0]   fpu_in1;
   logic [OPCODE_W-1:0] fpu_op;
   logic [DATA_W-1:0]   fpu_out0;
   logic                fpu_done;
   logic                fpu_overflow;
   logic                fpu_underflow;
   logic                fpu_div_by_zero;

   unum4_fpu_seq #(
      .DATA_W   (DATA_W),
      .OPCODE_W (OPCODE_W),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_op          (cmd_op),
      .cmd_a           (cmd_a),
      .cmd_b           (cmd_b),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .rsp_data        (rsp_data),
      .rsp_flags       (rsp_flags),
      .sticky_flags    (sticky_flags),
      .sticky_clr      (sticky_clr),
      .busy            (busy),
      .fpu_run         (fpu_run),
      .fpu_in0         (fpu_in0),
      .fpu_in1         (fpu_in1),
      .fpu_op          (fpu_op),
      .fpu_out0        (fpu_out0),
      .fpu_done        (fpu_done),
      .fpu_overflow    (fpu_overflow),
      .fpu_underflow   (fpu_underflow),
      .fpu_div_by_zero (fpu_div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_chk;
   int unsigned n_fail;
   logic [3:0]  sticky_exp;

   // Single comparison point: count, and report any mismatch
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Behavioural FPU: done L cycles after the run cycle, result a+b,
   // garbage on result/status whenever done is low.
   int unsigned mdl_lat;      // 0 means the FPU never completes
   logic [2:0]  mdl_flags;    // {div_by_zero, underflow, overflow}
   bit          inject_done;
   int unsigned mdl_rem;
   bit          mdl_pend;

   initial begin
      mdl_pend = 0;
      mdl_rem  = 0;
      fpu_done = 1'b0;
      fpu_out0 = '0;
      {fpu_div_by_zero, fpu_underflow, fpu_overflow} = 3'b000;
      forever begin
         @(negedge clk);
         #1;
         fpu_done = 1'b0;
         fpu_out0 = $urandom;
         {fpu_div_by_zero, fpu_underflow, fpu_overflow} = 3'($urandom);
         if (mdl_pend) begin
            mdl_rem--;
            if (mdl_rem == 0) begin
               mdl_pend = 0;
               fpu_done = 1'b1;
               fpu_out0 = fpu_in0 + fpu_in1;
               {fpu_div_by_zero, fpu_underflow, fpu_overflow} = mdl_flags;
            end
         end
         if (fpu_run && mdl_lat != 0) begin
            mdl_pend = 1;
            mdl_rem  = mdl_lat;
         end
         if (inject_done) fpu_done = 1'b1;
      end
   end

   // One full transaction; starts and ends just after a falling edge
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int unsigned lat, input logic [2:0] flg, input int unsigned hold,
                        input bit clr_entry, input bit keep_valid);
      int unsigned exp_cyc;
      int unsigned runs;
      int unsigned run_cyc;
      int unsigned rc;
      int unsigned w;
      logic [31:0] exp_data;
      logic [3:0]  exp_flags;
      logic [3:0]  exp_sticky;
      bit          done_wins;
      bit          hold_ok;

      done_wins  = (lat >= 1) && (lat <= TIMEOUT);
      exp_cyc    = done_wins ? 2 + lat : 2 + TIMEOUT;
      exp_data   = done_wins ? a + b : 32'h0;
      exp_flags  = done_wins ? {1'b0, flg} : 4'b1000;
      exp_sticky = clr_entry ? exp_flags : (sticky_exp | exp_flags);

      mdl_lat   = lat;
      mdl_flags = flg;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      rsp_ready = 1'b0;

      w = 0;
      while (!cmd_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      if (!cmd_ready) begin
         cmd_valid = 1'b0;
         return;
      end

      // cycle 0 ends at the next rising edge
      runs    = 0;
      run_cyc = 0;
      rc      = 0;
      for (int unsigned c = 1; c <= TIMEOUT + 10 && rc == 0; c++) begin
         @(negedge clk);
         if (!keep_valid) begin
            cmd_valid = 1'b0;
            cmd_a     = $urandom;
            cmd_b     = $urandom;
            cmd_op    = 2'($urandom);
         end
         sticky_clr = clr_entry && (c + 1 == exp_cyc);
         if (fpu_run) begin
            runs++;
            run_cyc = c;
         end
         if (rsp_valid) rc = c;
      end
      sticky_clr = 1'b0;

      chk("rsp_cycle", rc, exp_cyc);
      chk("rsp_data", rsp_data, exp_data);
      chk("rsp_flags", 32'(rsp_flags), 32'(exp_flags));
      chk("sticky", 32'(sticky_flags), 32'(exp_sticky));
      chk("fpu_in0", fpu_in0, a);
      chk("fpu_in1", fpu_in1, b);
      chk("fpu_op", 32'(fpu_op), 32'(op));
      chk("run_pulses", runs, 1);
      chk("run_cycle", run_cyc, 1);
      sticky_exp = exp_sticky;

      // consumer back-pressure: response and sticky must hold, no new issue
      hold_ok = 1;
      for (int unsigned i = 0; i < hold; i++) begin
         inject_done = (hold >= 3) && (i == 1);
         @(negedge clk);
         hold_ok &= rsp_valid && (rsp_data == exp_data) && (rsp_flags == exp_flags) &&
                    (sticky_flags == exp_sticky) && !cmd_ready && !fpu_run && busy;
      end
      inject_done = 0;
      if (hold > 0) chk("hold_stable", 32'(hold_ok), 32'd1);

      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("after_handshake", {28'h0, busy, rsp_valid, fpu_run, cmd_ready}, 32'h1);
      if (!keep_valid) cmd_valid = 1'b0;
   endtask

   // Idle cycles with an optional stray done; nothing may happen
   task automatic idle_watch(input int unsigned n, input int unsigned inj_idx);
      bit ok;
      ok = 1;
      for (int unsigned i = 1; i <= n; i++) begin
         inject_done = (i == inj_idx);
         @(negedge clk);
         ok &= !rsp_valid && !busy && !fpu_run && cmd_ready;
      end
      inject_done = 0;
      chk("idle_quiet", 32'(ok), 32'd1);
   endtask

   task automatic pulse_clr();
      sticky_clr = 1'b1;
      @(negedge clk);
      sticky_clr = 1'b0;
      sticky_exp = 4'b0000;
      chk("sticky_clr", 32'(sticky_flags), 32'h0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_data"}, rsp_data, 32'h0);
      chk({tag, "_in0"}, fpu_in0, 32'h0);
      chk({tag, "_in1"}, fpu_in1, 32'h0);
      chk({tag, "_ctrl"}, {18'h0, cmd_ready, rsp_valid, busy, fpu_run, fpu_op,
                           rsp_flags, sticky_flags}, 32'h0);
   endtask

   initial begin
      bit q_ok;
      logic [2:0] flg;
      int unsigned lat;
      n_chk       = 0;
      n_fail      = 0;
      sticky_exp  = 4'b0000;
      mdl_lat     = 0;
      mdl_flags   = 3'b000;
      inject_done = 0;
      rst         = 1'b1;
      cmd_valid   = 1'b0;
      cmd_op      = '0;
      cmd_a       = '0;
      cmd_b       = '0;
      rsp_ready   = 1'b0;
      sticky_clr  = 1'b0;

      // reset: everything zero while held, ready one cycle after release
      repeat (3) @(negedge clk);
      chk_all_zero("in_reset");
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", 32'(cmd_ready), 32'd1);

      // directed transactions
      do_op(OP_ADD, 32'd5, 32'd3, 10, 3'b000, 0, 0, 0);
      do_op(OP_DIV, 32'h40, 32'h0, 7, 3'b100, 0, 0, 0);
      do_op(OP_ADD, 32'h11, 32'h22, 4, 3'b000, 0, 0, 0);
      do_op(OP_MUL, 32'h1234, 32'h5678, 0, 3'b000, 0, 0, 0);  // timeout
      idle_watch(10, 6);                                       // stray done in cycle 135
      pulse_clr();
      do_op(OP_DIV, 32'h7, 32'h0, 3, 3'b100, 0, 0, 0);
      do_op(OP_SUB, 32'h100, 32'h23, 5, 3'b001, 0, 1, 0);      // clear meets set
      do_op(OP_ADD, 32'hAAAA, 32'h5555, 4, 3'b010, 20, 0, 1);  // back-pressure
      do_op(OP_SUB, 32'hFFFF_FFFF, 32'h2, 1, 3'b000, 0, 0, 0); // minimum latency
      do_op(OP_ADD, 32'h9, 32'h9, TIMEOUT, 3'b001, 0, 0, 0);   // done on last WAIT cycle
      do_op(OP_ADD, 32'h9, 32'h9, TIMEOUT + 1, 3'b010, 0, 0, 0); // done one cycle late

      // reset in the fifth WAIT cycle
      chk("pre_rst_ready", 32'(cmd_ready), 32'd1);
      mdl_lat   = 10;
      mdl_flags = 3'b001;
      cmd_valid = 1'b1;
      cmd_op    = OP_MUL;
      cmd_a     = 32'hDEAD;
      cmd_b     = 32'hBEEF;
      for (int unsigned c = 1; c <= 6; c++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
      end
      chk("busy_in_wait", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk_all_zero("mid_reset");
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_mid_reset", 32'(cmd_ready), 32'd1);
      sticky_exp = 4'b0000;
      q_ok = 1;
      for (int unsigned i = 0; i < 10; i++) begin
         @(negedge clk);
         q_ok &= !rsp_valid && !busy && !fpu_run && (sticky_flags == 4'b0000);
      end
      chk("no_rsp_after_reset", 32'(q_ok), 32'd1);

      // randomized traffic
      for (int unsigned n = 0; n < 30; n++) begin
         lat = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 16);
         flg = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
         if ($urandom_range(0, 7) == 0) pulse_clr();
         do_op(2'($urandom), $urandom, $urandom, lat, flg, $urandom_range(0, 3),
               $urandom_range(0, 5) == 0, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
